// File: rtl/mlp_train_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mlp_train_sequencer_if                                                     |
// | Sample/label/prediction bundle between the training sequencer and the MLP. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mlp_train_sequencer_if #(
   parameter int INPUTS  = 2,
   parameter int OUTPUTS = 1,
   parameter int DATA_W  = 64
);
   logic [INPUTS*DATA_W-1:0]  values_o;
   logic [OUTPUTS*DATA_W-1:0] expected_o;
   logic                      training_o;
   logic                      sample_valid_o;
   logic [OUTPUTS*DATA_W-1:0] prediction_i;

   modport master (
      output values_o, expected_o, training_o, sample_valid_o,
      input  prediction_i
   );

   modport slave (
      input  values_o, expected_o, training_o, sample_valid_o,
      output prediction_i
   );
endinterface
`default_nettype wire

// File: rtl/mlp_train_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mlp_train_sequencer                                                        |
// | Drives an MLP through train/evaluate epochs over a stored labelled dataset.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mlp_train_sequencer #(
   parameter int INPUTS   = 2,
   parameter int OUTPUTS  = 1,
   parameter int SAMPLES  = 4,
   parameter int DATA_W   = 64,
   parameter int FRAC_W   = 32,
   parameter int EPOCH_W  = 16,
   parameter int PRED_LAT = 1,
   localparam int AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
   localparam int CW = $clog2(SAMPLES + 1)
) (
   input  wire logic                      clk,
   input  wire logic                      rst,
   input  wire logic                      ld_en,
   input  wire logic [AW-1:0]             ld_addr,
   input  wire logic [INPUTS*DATA_W-1:0]  ld_x,
   input  wire logic [OUTPUTS*DATA_W-1:0] ld_y,
   input  wire logic                      start,
   input  wire logic [EPOCH_W-1:0]        num_epochs,
   input  wire logic [DATA_W-1:0]         threshold,
   input  wire logic                      early_stop,
   mlp_train_sequencer_if.master          mlp,
   output logic                           busy,
   output logic                           done,
   output logic [CW-1:0]                  correct_o,
   output logic                           all_correct,
   output logic [EPOCH_W-1:0]             epochs_run
);
   localparam int              c_DW         = (PRED_LAT > 1) ? $clog2(PRED_LAT) : 1;
   localparam int              c_XW         = INPUTS * DATA_W;
   localparam int              c_YW         = OUTPUTS * DATA_W;
   localparam logic [AW-1:0]   c_LAST_IDX   = AW'(SAMPLES - 1);
   localparam logic [c_DW-1:0] c_LAST_DRAIN = c_DW'(PRED_LAT - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TRAIN = 3'd1,
      ST_EVAL  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_SCORE = 3'd4
   } state_t;

   if (FRAC_W >= DATA_W || PRED_LAT < 1 || SAMPLES < 1) begin : g_param_check
      $error("mlp_train_sequencer: illegal parameter combination");
   end

   state_t                    r_state, w_state_nxt;
   logic [AW-1:0]             r_idx;
   logic [c_DW-1:0]           r_drain;
   logic [c_XW-1:0]           r_ram_x [SAMPLES];
   logic [c_YW-1:0]           r_ram_y [SAMPLES];
   logic [EPOCH_W-1:0]        r_num_epochs;
   logic [EPOCH_W-1:0]        r_epochs_run;
   logic signed [DATA_W-1:0]  r_threshold;
   logic                      r_early_stop;
   logic [c_YW-1:0]           r_lbl_pipe [PRED_LAT];
   logic [PRED_LAT-1:0]       r_vld_pipe;
   logic [CW-1:0]             r_acc;
   logic [CW-1:0]             r_correct;
   logic                      r_all_correct;
   logic                      w_sample_valid;
   logic                      w_finish;
   logic                      w_hit;
   logic                      w_addr_ok;
   logic [CW-1:0]             w_acc_nxt;
   logic [OUTPUTS-1:0]        w_match;

   assign w_finish  = (r_epochs_run == r_num_epochs) || (r_early_stop && r_all_correct);
   assign w_hit     = r_vld_pipe[PRED_LAT-1] & (&w_match);
   assign w_acc_nxt = r_acc + CW'(w_hit);

   always_comb begin
      w_state_nxt    = r_state;
      w_sample_valid = 1'b0;
      mlp.training_o = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = (num_epochs != '0) ? ST_TRAIN : ST_EVAL;
         end
         ST_TRAIN: begin
            w_sample_valid = 1'b1;
            mlp.training_o = 1'b1;
            if (r_idx == c_LAST_IDX) w_state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            w_sample_valid = 1'b1;
            if (r_idx == c_LAST_IDX) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_drain == c_LAST_DRAIN) w_state_nxt = ST_SCORE;
         end
         ST_SCORE: begin
            done        = w_finish;
            w_state_nxt = w_finish ? ST_IDLE : ST_TRAIN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   assign mlp.sample_valid_o = w_sample_valid;
   assign mlp.values_o       = w_sample_valid ? r_ram_x[r_idx] : '0;
   assign mlp.expected_o     = w_sample_valid ? r_ram_y[r_idx] : '0;

   // Out-of-range addresses only exist when SAMPLES is not a power of two.
   if ((1 << AW) > SAMPLES) begin : g_addr_chk
      assign w_addr_ok = (ld_addr <= c_LAST_IDX);
   end else begin : g_addr_full
      assign w_addr_ok = 1'b1;
   end

   // Dataset storage survives reset so a run can restart without reloading.
   always_ff @(posedge clk) begin
      if (ld_en && r_state == ST_IDLE && w_addr_ok) begin
         r_ram_x[ld_addr] <= ld_x;
         r_ram_y[ld_addr] <= ld_y;
      end
   end

   for (genvar j = 0; j < OUTPUTS; j++) begin : g_cmp
      logic signed [DATA_W-1:0] w_pred;
      logic signed [DATA_W-1:0] w_lbl;
      assign w_pred     = mlp.prediction_i[j*DATA_W +: DATA_W];
      assign w_lbl      = r_lbl_pipe[PRED_LAT-1][j*DATA_W +: DATA_W];
      assign w_match[j] = (w_pred < r_threshold) == (w_lbl < r_threshold);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx         <= '0;
         r_drain       <= '0;
         r_num_epochs  <= '0;
         r_epochs_run  <= '0;
         r_threshold   <= '0;
         r_early_stop  <= 1'b0;
         r_vld_pipe    <= '0;
         r_acc         <= '0;
         r_correct     <= '0;
         r_all_correct <= 1'b0;
         for (int k = 0; k < PRED_LAT; k++) r_lbl_pipe[k] <= '0;
      end else begin
         r_idx   <= (w_state_nxt != r_state) ? '0 :
                    (w_sample_valid ? r_idx + AW'(1) : r_idx);
         r_drain <= (r_state == ST_DRAIN && w_state_nxt == ST_DRAIN) ? r_drain + c_DW'(1) : '0;

         if (r_state == ST_IDLE && start) begin
            r_num_epochs <= num_epochs;
            r_threshold  <= threshold;
            r_early_stop <= early_stop;
            r_epochs_run <= '0;
         end else if (r_state == ST_TRAIN && w_state_nxt == ST_EVAL) begin
            r_epochs_run <= r_epochs_run + EPOCH_W'(1);
         end

         // Label travels alongside the MLP latency so it meets its own prediction.
         r_lbl_pipe[0] <= (r_state == ST_EVAL) ? r_ram_y[r_idx] : '0;
         r_vld_pipe[0] <= (r_state == ST_EVAL);
         for (int k = 1; k < PRED_LAT; k++) begin
            r_lbl_pipe[k] <= r_lbl_pipe[k-1];
            r_vld_pipe[k] <= r_vld_pipe[k-1];
         end

         if (w_state_nxt == ST_EVAL && r_state != ST_EVAL) r_acc <= '0;
         else                                              r_acc <= w_acc_nxt;

         if (r_state == ST_DRAIN && w_state_nxt == ST_SCORE) begin
            r_correct     <= w_acc_nxt;
            r_all_correct <= (w_acc_nxt == CW'(SAMPLES));
         end
      end
   end

   assign correct_o   = r_correct;
   assign all_correct = r_all_correct;
   assign epochs_run  = r_epochs_run;
endmodule
`default_nettype wire

// File: tb/tb_mlp_train_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mlp_train_sequencer                                                     |
// | Scoreboard bench: XOR dataset, delayed-echo MLP stub, directed runs.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mlp_train_sequencer;
   localparam int INPUTS = 2, OUTPUTS = 1, SAMPLES = 4, DATA_W = 64;
   localparam int FRAC_W = 32, EPOCH_W = 16, PRED_LAT = 1;
   localparam logic [63:0] c_ONE  = 64'h1_0000_0000;
   localparam logic [63:0] c_HALF = 64'h0_8000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ld_en = 1'b0;
   logic [1:0]    ld_addr = '0;
   logic [127:0]  ld_x = '0;
   logic [63:0]   ld_y = '0;
   logic          start = 1'b0;
   logic [15:0]   num_epochs = '0;
   logic [63:0]   threshold = '0;
   logic          early_stop = 1'b0;
   logic          busy, done, all_correct;
   logic [2:0]    correct_o;
   logic [15:0]   epochs_run;
   logic          bad_stub = 1'b0;
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;

   mlp_train_sequencer_if #(.INPUTS(INPUTS), .OUTPUTS(OUTPUTS), .DATA_W(DATA_W)) mif ();

   mlp_train_sequencer #(
      .INPUTS(INPUTS), .OUTPUTS(OUTPUTS), .SAMPLES(SAMPLES), .DATA_W(DATA_W),
      .FRAC_W(FRAC_W), .EPOCH_W(EPOCH_W), .PRED_LAT(PRED_LAT)
   ) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
      .start(start), .num_epochs(num_epochs), .threshold(threshold), .early_stop(early_stop),
      .mlp(mif), .busy(busy), .done(done), .correct_o(correct_o),
      .all_correct(all_correct), .epochs_run(epochs_run)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // MLP stand-in: echoes the label one cycle later, optionally wrong on [1,1].
   always @(posedge clk)
      mif.prediction_i <= (bad_stub && mif.values_o == {c_ONE, c_ONE}) ? c_ONE : mif.expected_o;

   logic [127:0] m_x [SAMPLES];
   logic [63:0]  m_y [SAMPLES];
   initial begin
      m_x[0] = {64'd0, 64'd0};  m_y[0] = 64'd0;
      m_x[1] = {64'd0, c_ONE};  m_y[1] = c_ONE;
      m_x[2] = {c_ONE, 64'd0};  m_y[2] = c_ONE;
      m_x[3] = {c_ONE, c_ONE};  m_y[3] = 64'd0;
   end

   typedef struct {
      int t0; int done_rel; int corr; bit allc; int ep; int trn; int vld; int first_trn;
   } exp_t;
   exp_t sbq[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: follows samples against the dataset model, scores each done.
   initial begin
      int   sidx = 0, trn = 0, vld = 0, first_trn = -1, first_vld = -1;
      bit   prev_done = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (prev_done) check("busy_after_done", busy, 0);
         prev_done = done;
         if (rst) begin
            sidx = 0; trn = 0; vld = 0; first_trn = -1; first_vld = -1;
         end else begin
            if (mif.sample_valid_o) begin
               check("values_o", mif.values_o, m_x[sidx]);
               check("expected_o", mif.expected_o, m_y[sidx]);
               sidx = (sidx + 1) % SAMPLES;
               vld++;
               if (first_vld < 0) first_vld = cyc;
            end else begin
               check("values_idle", {mif.values_o[63:0], mif.expected_o}, 0);
            end
            if (mif.training_o) begin
               trn++;
               if (first_trn < 0) first_trn = cyc;
            end
            if (done) begin
               if (sbq.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  check("done_cycle", cyc - e.t0, e.done_rel);
                  check("correct_o", correct_o, e.corr);
                  check("all_correct", all_correct, e.allc);
                  check("epochs_run", epochs_run, e.ep);
                  check("train_cycles", trn, e.trn);
                  check("valid_cycles", vld, e.vld);
                  check("first_valid", first_vld - e.t0, 1);
                  check("first_train", (first_trn < 0) ? -1 : first_trn - e.t0, e.first_trn);
               end
               trn = 0; vld = 0; first_trn = -1; first_vld = -1;
            end
         end
      end
   end

   task automatic start_run(input int ne, input bit es, input bit push, input int done_rel,
                            input int corr, input bit allc, input int ep, input int trn,
                            input int vld, input int first_trn, output int t0);
      @(posedge clk); #1;
      num_epochs = 16'(ne); early_stop = es; threshold = c_HALF; start = 1'b1;
      t0 = cyc;
      if (push) sbq.push_back('{t0, done_rel, corr, allc, ep, trn, vld, first_trn});
      @(posedge clk); #1;
      // Scramble config to show it was latched at start.
      start = 1'b0; num_epochs = 16'hDEAD; early_stop = ~es; threshold = '0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (busy && n < 2000);
      check(name, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_ctrl", {busy, done, correct_o, all_correct, epochs_run,
                            mif.training_o, mif.sample_valid_o, mif.expected_o}, 0);
         check("rst_values", mif.values_o, 0);
      end
      rst = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         check("idle_ctrl", {busy, done, correct_o, all_correct, epochs_run,
                             mif.training_o, mif.sample_valid_o, mif.expected_o}, 0);
      end

      for (int i = 0; i < SAMPLES; i++) begin
         @(posedge clk); #1;
         ld_en = 1'b1; ld_addr = 2'(i); ld_x = m_x[i]; ld_y = m_y[i];
      end
      @(posedge clk); #1;
      ld_en = 1'b0;

      // Three full epochs; a load and a start arrive mid-run and must be ignored.
      start_run(3, 1'b0, 1'b1, 30, 4, 1'b1, 3, 12, 24, 1, t0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = 2'd0; ld_x = '1; ld_y = c_ONE; start = 1'b1; num_epochs = '0;
      @(posedge clk); #1;
      ld_en = 1'b0; start = 1'b0;
      wait_idle("idle_run_a");

      start_run(100, 1'b1, 1'b1, 10, 4, 1'b1, 1, 4, 8, 1, t0);
      wait_idle("idle_run_b");

      bad_stub = 1'b1;
      start_run(2, 1'b1, 1'b1, 20, 3, 1'b0, 2, 8, 16, 1, t0);
      wait_idle("idle_run_c");
      bad_stub = 1'b0;

      start_run(0, 1'b0, 1'b1, 6, 4, 1'b1, 0, 0, 4, -1, t0);
      wait_idle("idle_run_d");

      // Abort mid-run: nothing queued, so any done here is reported.
      start_run(3, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, t0);
      while (cyc < t0 + 7) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_ctrl", {busy, done, all_correct, epochs_run, mif.training_o,
                           mif.sample_valid_o, mif.expected_o}, 0);
      check("abort_correct", correct_o, 0);
      check("abort_values", mif.values_o, 0);
      rst = 1'b0;
      repeat (40) begin @(posedge clk); #1; end

      start_run(1, 1'b0, 1'b1, 10, 4, 1'b1, 1, 4, 8, 1, t0);
      wait_idle("idle_run_f");

      repeat (3) @(posedge clk);
      check("scoreboard_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mlp_train_sequencer.md
# mlp_train_sequencer

Hardware replacement for the hand-written XOR training bench. It holds a parametrised labelled dataset and drives an `MLP` instance through repeated train/evaluate epochs. During evaluation it scores each prediction against a threshold and reports per-epoch classification accuracy. It sits directly in front of `MLP`, owns the `training`/`values`/`expected` inputs, and supports early stop once every sample classifies correctly.

## Interface
- `INPUTS`, 2, features per sample
- `OUTPUTS`, 1, outputs per sample
- `SAMPLES`, 4, dataset depth (≥1)
- `DATA_W`, 64, sfp width (signed fixed point)
- `FRAC_W`, 32, fractional bits; ONE = 2^FRAC_W, HALF = 2^(FRAC_W-1)
- `EPOCH_W`, 16, epoch counter width
- `PRED_LAT`, 1, cycles from `values_o` driven to `prediction_i` valid (≥1)

Ports (AW = $clog2(SAMPLES), CW = $clog2(SAMPLES+1)):
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `ld_en` in 1: dataset write strobe
- `ld_addr` in AW: sample index to write
- `ld_x` in INPUTS*DATA_W: sample features
- `ld_y` in OUTPUTS*DATA_W: sample labels
- `start` in 1: begin run
- `num_epochs` in EPOCH_W: training epochs to run
- `threshold` in DATA_W: classification threshold (signed)
- `early_stop` in 1: stop after the first fully-correct epoch
- `prediction_i` in OUTPUTS*DATA_W: MLP output
- `values_o` out INPUTS*DATA_W: MLP input
- `expected_o` out OUTPUTS*DATA_W: MLP label
- `training_o` out 1: MLP training enable
- `sample_valid_o` out 1: a sample is being presented this cycle
- `busy` out 1: run in progress
- `done` out 1: one-cycle completion pulse
- `correct_o` out CW: correctly classified samples in the last evaluation
- `all_correct` out 1: `correct_o == SAMPLES`
- `epochs_run` out EPOCH_W: training epochs completed

## Operation
- Dataset RAM: SAMPLES entries of {x, y}. `ld_en` writes while in IDLE only; the write is ignored while `busy`. RAM contents are not cleared by `rst`.
- `start` and config inputs are sampled in IDLE only. `start` while busy is ignored. `num_epochs`, `threshold`, and `early_stop` are latched at start.
- States:
  - IDLE
  - TRAIN: samples 0..SAMPLES-1, one per cycle, `training_o`=1.
  - EVAL: samples 0..SAMPLES-1, one per cycle, `training_o`=0.
  - DRAIN: PRED_LAT cycles, no sample.
  - SCORE: 1 cycle.
- Transitions:
  - IDLE→TRAIN on start when latched `num_epochs`>0; IDLE→EVAL when it is 0.
  - TRAIN→EVAL→DRAIN→SCORE.
  - SCORE→IDLE when `epochs_run`==`num_epochs`, or when `early_stop` and `all_correct`. Otherwise SCORE→TRAIN.
- `epochs_run` increments on each TRAIN→EVAL transition.
- `values_o`/`expected_o` present RAM[idx] when `sample_valid_o`=1 and are 0 otherwise. `sample_valid_o`=1 in TRAIN and EVAL only.
- Scoring:
  - The EVAL label and a valid flag are delayed PRED_LAT cycles through a shift register.
  - Output j matches iff ((pred_j < thr) == (exp_j < thr)), signed compare. `pred == thr` counts as not-below.
  - A sample is correct iff all OUTPUTS match. The accumulator is cleared on entering EVAL.
- On the edge entering SCORE, register `correct_o` and `all_correct`. `done`=1 only during the final SCORE cycle of a run.
- `busy`=1 in every state except IDLE.

## Timing
- Start is sampled at cycle 0, and the first sample is presented at cycle 1.
- Epoch length is L = 2·SAMPLES + PRED_LAT + 1 cycles. The SCORE of epoch e (1-based) falls at cycle L·e.
- The eval-only run (`num_epochs`=0) has its SCORE/`done` at cycle SAMPLES + PRED_LAT + 1.
- `busy` falls in the cycle after `done`, and a new `start` is accepted that cycle.
- Reset values: all outputs 0; state IDLE; counters, pipeline, and latched config cleared.
- Reset mid-run aborts immediately with no `done` pulse. The RAM is retained, so a restart needs no reload.

## Test plan
- Reset → every output 0, `busy`=0. Assert `rst` for 3 cycles, then hold idle for 5 → outputs remain 0.
- XOR dataset loaded, stub `prediction_i` = `expected_o` delayed 1, threshold HALF, `num_epochs`=3, `early_stop`=0 → `training_o` high cycles 1–4, 11–14, 21–24; `done` at cycle 30; `correct_o`=4, `all_correct`=1, `epochs_run`=3.
- Same setup with `num_epochs`=100, `early_stop`=1 → `done` at cycle 10, `epochs_run`=1.
- Stub returns ONE for [1,1] → `correct_o`=3, `all_correct`=0; with `early_stop`=1 and `num_epochs`=2, `done` at cycle 20.
- `num_epochs`=0 → no `training_o`; EVAL cycles 1–4; `done` at cycle 6, `epochs_run`=0.
- Pulse `rst` at cycle 7 of a run → outputs 0 next cycle, no `done`. Then restart without reload → `correct_o`=4. Also, `start`/`ld_en` issued while busy → ignored, and RAM is unchanged.
